// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared definitions for the 5-stage pipeline stall/flush sequencer.
//   - Stage bit indices into the stall/flush vectors (bit0=PC ... bit4=MEM/WB).
//   - Sequencer state encodings.
//   - Stall/flush patterns for each hazard class.
//   - Generic signal-level constants.
// No ports (package).

package pipeline_ctrl_pkg;

    // Bit positions in stall/flush vectors, named after the stage a register feeds.
    localparam int unsigned STG_PC  = 0;  // program counter
    localparam int unsigned STG_ID  = 1;  // IF/ID register
    localparam int unsigned STG_EX  = 2;  // ID/EX register
    localparam int unsigned STG_MEM = 3;  // EX/MEM register
    localparam int unsigned STG_WB  = 4;  // MEM/WB register

    typedef logic [4:0] stage_vec_t;

    // Sequencer states
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] DIV_WAIT = 2'd1;
    localparam logic [1:0] MEM_WAIT = 2'd2;

    // Hazard patterns: whatever is held upstream, a bubble goes in just below it.
    localparam stage_vec_t VEC_NONE  = 5'b00000;
    localparam stage_vec_t MEM_STALL = 5'b01111;
    localparam stage_vec_t MEM_FLUSH = 5'b10000;
    localparam stage_vec_t DIV_STALL = 5'b00111;
    localparam stage_vec_t DIV_FLUSH = 5'b01000;
    localparam stage_vec_t BR_STALL  = 5'b00000;
    localparam stage_vec_t BR_FLUSH  = 5'b00110;
    localparam stage_vec_t LU_STALL  = 5'b00011;
    localparam stage_vec_t LU_FLUSH  = 5'b00100;

    localparam logic RstEnable  = 1'b1;
    localparam logic OneSignal  = 1'b1;
    localparam logic ZeroSignal = 1'b0;

endpackage

// File: rtl/pipeline_hazard_detect.sv
// pipeline_hazard_detect
//   Purely combinational load-use comparator. Flags when the load in EX writes a
//   register that the instruction in ID actually reads. x0 never creates a hazard.
// Ports:
//   ex_mem_read_i   EX instruction is a load
//   ex_rd_i         EX destination register
//   id_rs1_i/rs2_i  ID source registers
//   id_rs1_used_i   ID reads rs1
//   id_rs2_used_i   ID reads rs2
//   load_use_o      load-use interlock required

module pipeline_hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    output logic                  load_use_o
);

    logic rs1_hit;
    logic rs2_hit;
    logic rd_nonzero;

    assign rs1_hit    = id_rs1_used_i & (id_rs1_i == ex_rd_i);
    assign rs2_hit    = id_rs2_used_i & (id_rs2_i == ex_rd_i);
    assign rd_nonzero = (ex_rd_i != '0);
    assign load_use_o = (ex_mem_read_i == OneSignal) & rd_nonzero & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Central stall/flush sequencer for the 5-stage RV32 pipeline. Arbitrates
//   (highest first) MEM bus wait > multi-cycle divide > branch redirect > load-use,
//   sequences the divider start/done handshake and aborts stuck bus accesses.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   branch_enable_i     EX branch/jump taken
//   ex_mem_read_i, ex_rd_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i
//                       load-use comparator inputs
//   div_req_i, div_done_i   divide in EX / divider result valid pulse
//   mem_req_i, mem_ack_i    MEM bus access active / complete
//   stall_o, flush_o    per-register hold / bubble (bit0=PC .. bit4=MEM/WB)
//   div_start_o         registered 1-cycle divider start
//   bus_err_o           registered 1-cycle wait-state timeout
//   stall_cnt_o, flush_cnt_o  performance counters (PIPE_PERF_CNT_EN only)
// Build option: define PIPE_PERF_CNT_EN to add the performance counters.

module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned REG_ADDR_W  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  branch_enable_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic                  div_req_i,
    input  logic                  div_done_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ack_i,
    output logic [4:0]            stall_o,
    output logic [4:0]            flush_o,
    output logic                  div_start_o,
    output logic                  bus_err_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           flush_cnt_o
`endif
);

    localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       branch_pend_q, branch_pend_d;
    logic       div_mask_q, div_mask_d;
    logic       div_start_q, div_start_d;
    logic       bus_err_q, bus_err_d;

    logic load_use;
    logic mem_wait;
    logic div_req_eff;
    logic timeout;
    logic div_hold;
    logic hi_stall;
    logic branch_flush;

    pipeline_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .ex_mem_read_i (ex_mem_read_i),
        .ex_rd_i       (ex_rd_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .load_use_o    (load_use)
    );

    // The abort cycle releases the stall even if the bus unit still holds mem_req_i.
    assign mem_wait    = mem_req_i & ~mem_ack_i & ~bus_err_q;
    // One-cycle mask after done keeps the finishing DIV from re-launching.
    assign div_req_eff = div_req_i & ~div_mask_q;
    assign timeout     = mem_wait & (wait_cnt_q == TimeoutLast);
    // Leaving MEM_WAIT on ack behaves like RUN, so a divide can start that cycle.
    assign div_hold    = ((state_q != DIV_WAIT) & div_req_eff) |
                         ((state_q == DIV_WAIT) & ~div_done_i);
    assign hi_stall    = mem_wait | div_hold;
    assign branch_flush = ~hi_stall & (branch_enable_i | branch_pend_q);

    always_comb begin
        stall_o = VEC_NONE;
        flush_o = VEC_NONE;
        if (mem_wait) begin
            stall_o = MEM_STALL;
            flush_o = MEM_FLUSH;
        end else if (div_hold) begin
            stall_o = DIV_STALL;
            flush_o = DIV_FLUSH;
        end else if (branch_flush) begin
            // Branch squashes ID, so any load-use on it is moot.
            stall_o = BR_STALL;
            flush_o = BR_FLUSH;
        end else if (load_use) begin
            stall_o = LU_STALL;
            flush_o = LU_FLUSH;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        branch_pend_d = branch_pend_q;
        div_mask_d    = ZeroSignal;
        div_start_d   = ZeroSignal;
        bus_err_d     = ZeroSignal;

        if (mem_wait) begin
            if (timeout) begin
                state_d    = RUN;
                wait_cnt_d = '0;
                bus_err_d  = OneSignal;
            end else begin
                state_d    = MEM_WAIT;
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end else begin
            wait_cnt_d = '0;
            if (state_q == DIV_WAIT) begin
                if (div_done_i) begin
                    state_d    = RUN;
                    div_mask_d = OneSignal;
                end
            end else if (div_req_eff) begin
                state_d     = DIV_WAIT;
                div_start_d = OneSignal;
            end else begin
                state_d = RUN;
            end
        end

        // Pending redirect survives stalls; it is consumed by the first free cycle.
        if (hi_stall) begin
            if (branch_enable_i) begin
                branch_pend_d = OneSignal;
            end
        end else begin
            branch_pend_d = ZeroSignal;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i == RstEnable) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            branch_pend_q <= ZeroSignal;
            div_mask_q    <= ZeroSignal;
            div_start_q   <= ZeroSignal;
            bus_err_q     <= ZeroSignal;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            branch_pend_q <= branch_pend_d;
            div_mask_q    <= div_mask_d;
            div_start_q   <= div_start_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign div_start_o = div_start_q;
    assign bus_err_o   = bus_err_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i == RstEnable) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_o[STG_PC]) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_o != VEC_NONE) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Directed bench for pipeline_ctrl (MEM_TIMEOUT=4): a per-cycle vector table
//   followed by hand-written divide, timeout and reset sequences.

module tb_pipeline_ctrl;

    localparam int unsigned MemTimeout = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       branch_enable;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic       div_req;
    logic       div_done;
    logic       mem_req;
    logic       mem_ack;
    logic [4:0] stall;
    logic [4:0] flush;
    logic       div_start;
    logic       bus_err;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .MEM_TIMEOUT (MemTimeout),
        .REG_ADDR_W  (5)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .branch_enable_i (branch_enable),
        .ex_mem_read_i   (ex_mem_read),
        .ex_rd_i         (ex_rd),
        .id_rs1_i        (id_rs1),
        .id_rs2_i        (id_rs2),
        .id_rs1_used_i   (id_rs1_used),
        .id_rs2_used_i   (id_rs2_used),
        .div_req_i       (div_req),
        .div_done_i      (div_done),
        .mem_req_i       (mem_req),
        .mem_ack_i       (mem_ack),
        .stall_o         (stall),
        .flush_o         (flush),
        .div_start_o     (div_start),
        .bus_err_o       (bus_err)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt)
`endif
    );

    typedef struct {
        logic       rst;
        logic       br;
        logic       ld;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       dreq;
        logic       ddone;
        logic       mreq;
        logic       mack;
        logic [4:0] es;
        logic [4:0] ef;
        logic       eds;
        logic       ebe;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic br, input logic ld, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic dreq, input logic ddone, input logic mreq,
                       input logic mack, input logic [4:0] es, input logic [4:0] ef,
                       input logic eds, input logic ebe);
        vec_t v;
        v.rst = r;   v.br = br;     v.ld = ld;     v.rd = rd;
        v.rs1 = rs1; v.rs2 = rs2;   v.u1 = u1;     v.u2 = u2;
        v.dreq = dreq; v.ddone = ddone; v.mreq = mreq; v.mack = mack;
        v.es = es;   v.ef = ef;     v.eds = eds;   v.ebe = ebe;
        vecs.push_back(v);
    endtask

    task automatic zero_inputs();
        branch_enable = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0;
        id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0; div_req = 1'b0;
        div_done = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        zero_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check(input string name, input int idx, input logic [4:0] got,
                         input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %b expected %b", name, idx, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        zero_inputs();

        //   rst br ld rd    rs1   rs2   u1 u2 dq dd mq ma stall     flush     ds be
        add(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0); // 0 in reset
        add(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0); // 1 idle
        add(0, 0, 1, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 0, 0, 5'b00011, 5'b00100, 0, 0); // 2 lu rs2
        add(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0); // 3
        add(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0); // 4 rd=x0
        add(0, 0, 1, 5'd7, 5'd7, 5'd3, 1, 0, 0, 0, 0, 0, 5'b00011, 5'b00100, 0, 0); // 5 lu rs1
        add(0, 0, 1, 5'd7, 5'd7, 5'd3, 0, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0); // 6 rs1 unused
        add(0, 0, 0, 5'd9, 5'd1, 5'd9, 1, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0); // 7 not load
        add(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00110, 0, 0); // 8 branch
        add(0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 0, 0, 5'b00000, 5'b00110, 0, 0); // 9 br+lu
        add(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 5'b01111, 5'b10000, 0, 0); // 10 mem+br
        add(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 5'b01111, 5'b10000, 0, 0); // 11
        add(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 5'b01111, 5'b10000, 0, 0); // 12
        add(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1, 5'b00000, 5'b00110, 0, 0); // 13 ack
        add(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0); // 14 once
        add(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1, 5'b00000, 5'b00000, 0, 0); // 15 fast ack
        add(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 5'b01111, 5'b10000, 0, 0); // 16 mem
        add(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, 1, 5'b00111, 5'b01000, 0, 0); // 17 ack+div
        add(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 5'b00111, 5'b01000, 1, 0); // 18
        add(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0, 5'b00000, 5'b00000, 0, 0); // 19 done
        add(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 5'b00000, 5'b00000, 0, 0); // 20 masked
        add(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0); // 21
        add(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 5'b00000, 5'b00000, 0, 0); // 22 stray done
        add(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 5'b00111, 5'b01000, 0, 0); // 23 div
        add(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 5'b00111, 5'b01000, 1, 0); // 24 div+br
        add(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0, 5'b00000, 5'b00110, 0, 0); // 25 done
        add(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0); // 26

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; branch_enable = vecs[i].br; ex_mem_read = vecs[i].ld;
            ex_rd = vecs[i].rd; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_rs1_used = vecs[i].u1; id_rs2_used = vecs[i].u2; div_req = vecs[i].dreq;
            div_done = vecs[i].ddone; mem_req = vecs[i].mreq; mem_ack = vecs[i].mack;
            #2;
            check("vec_stall", i, stall, vecs[i].es);
            check("vec_flush", i, flush, vecs[i].ef);
            check("vec_div_start", i, {4'b0, div_start}, {4'b0, vecs[i].eds});
            check("vec_bus_err", i, {4'b0, bus_err}, {4'b0, vecs[i].ebe});
        end

        // Divide: request from cycle 10, done at 45, request still high at 46.
        do_reset();
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            div_req  = (c >= 10 && c <= 46);
            div_done = (c == 45);
            #2;
            if (c >= 9) begin
                check("div_stall", c, stall, (c >= 10 && c <= 44) ? 5'b00111 : 5'b00000);
                check("div_start", c, {4'b0, div_start}, (c == 11) ? 5'd1 : 5'd0);
            end
        end

        // Timeout: request held with no ack through the abort cycle.
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            mem_req = (c <= 4);
            #2;
            check("to_stall", c, stall, (c <= 3) ? 5'b01111 : 5'b00000);
            check("to_flush", c, flush, (c <= 3) ? 5'b10000 : 5'b00000);
            check("to_bus_err", c, {4'b0, bus_err}, (c == 4) ? 5'd1 : 5'd0);
        end

        // Reset mid-DIV_WAIT, then mid-MEM_WAIT on the would-be timeout cycle.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            zero_inputs();
            rst      = (c == 2) || (c == 9);
            div_req  = (c <= 2);
            div_done = (c == 4);
            mem_req  = (c >= 6 && c <= 9);
            #2;
            if (c == 1) begin
                check("rst_div_start", c, {4'b0, div_start}, 5'd1);
            end
            if (c == 3 || c == 4 || c == 5 || c == 10 || c == 11) begin
                check("rst_stall", c, stall, 5'b00000);
                check("rst_flush", c, flush, 5'b00000);
                check("rst_div_start", c, {4'b0, div_start}, 5'd0);
                check("rst_bus_err", c, {4'b0, bus_err}, 5'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32 pipeline (IF, ID, EX, MEM, WB).
- Arbitrates four hazard sources and drives per-register stall and flush vectors to the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Hazard sources: data-bus wait states, multi-cycle divide, EX-resolved branch redirect, load-use interlock.
- Sequences the iterative divider through a start/done handshake.
- Guards the data bus with a wait-state timeout.

Parameters:
MEM_TIMEOUT, 255, max consecutive MEM wait cycles before an abort; range 1..255; counter is 8 bits.
REG_ADDR_W, 5, register-index width.

Ports:
clk_i  in  1  core clock
rst_i  in  1  reset, synchronous, active-high
branch_enable_i  in  1  EX-stage branch/jump taken (redirect)
ex_mem_read_i  in  1  instruction in EX is a load
ex_rd_i  in  REG_ADDR_W  EX destination register
id_rs1_i  in  REG_ADDR_W  ID source 1
id_rs2_i  in  REG_ADDR_W  ID source 2
id_rs1_used_i  in  1  ID reads rs1
id_rs2_used_i  in  1  ID reads rs2
div_req_i  in  1  instruction in EX is DIV/REM
div_done_i  in  1  divider result valid (1-cycle pulse)
mem_req_i  in  1  MEM-stage bus access active
mem_ack_i  in  1  bus access complete
stall_o  out  5  hold enable, bit0=PC, 1=IF/ID, 2=ID/EX, 3=EX/MEM, 4=MEM/WB
flush_o  out  5  bubble insert, same bit map
div_start_o  out  1  registered 1-cycle divider start pulse
bus_err_o  out  1  registered 1-cycle timeout pulse

Behaviour:
- Reset: all of the following are zero:
  - state=RUN
  - stall_o, flush_o, div_start_o, bus_err_o
  - wait_cnt
  - branch_pend
- State register encoding: RUN, DIV_WAIT, MEM_WAIT.
- stall_o and flush_o are combinational from current state, branch_pend and inputs.
- Priority, highest first: mem wait > divide > branch > load-use.
- mem_wait = mem_req_i & ~mem_ack_i.
  - Drive stall_o=01111, flush_o=10000.
  - RUN or DIV_WAIT -> MEM_WAIT; wait_cnt increments each MEM_WAIT cycle.
  - mem_ack_i: release stalls the same cycle, state->RUN, wait_cnt=0.
  - wait_cnt==MEM_TIMEOUT-1 with no ack: bus_err_o=1 next cycle, state->RUN, wait_cnt=0. The stall releases in that cycle; the bus unit owns the abort.
- Divide, in RUN with div_req_i and no mem_wait:
  - div_start_o=1 next cycle; state->DIV_WAIT.
  - In RUN with div_req_i and in DIV_WAIT: stall_o=00111, flush_o=01000.
  - div_done_i in DIV_WAIT: stalls released the same cycle; state->RUN.
  - div_done_i outside DIV_WAIT is ignored.
  - After done, div_req_i is masked for exactly one cycle so the same instruction does not restart the divider.
- Branch:
  - branch_enable_i with no higher-priority hazard: flush_o=00110, no stall.
  - branch_enable_i during mem_wait or DIV_WAIT: set branch_pend. The flush is applied in the first non-stalled cycle, then branch_pend clears.
  - A second branch while pending has no additional effect.
- Load-use:
  - Condition: ex_mem_read_i & ex_rd_i!=0 & ((rs1 match & rs1_used) | (rs2 match & rs2_used)).
  - Drive stall_o=00011, flush_o=00100 for that cycle only.
  - Suppressed when a branch flush is asserted in the same cycle, because the ID instruction is squashed.
- Simultaneous events:
  - mem_ack_i and div_req_i in the same cycle: mem releases, and divide start is evaluated in that cycle.
  - rst_i mid-DIV_WAIT or mid-MEM_WAIT: return to RUN; branch_pend and counters clear; no div_start or bus_err pulse.
- A stage is never both stalled and flushed.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o increments on every cycle where stall_o[0] is set.
  - flush_cnt_o increments on every cycle where flush_o is nonzero.
  - Both wrap at 2^32 and clear on rst_i.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared define file holds:
  - the stage bit indices STG_PC..STG_WB
  - the state encodings RUN/DIV_WAIT/MEM_WAIT
  - the vector constants for the mem/div/branch/load-use stall and flush patterns
  - RstEnable/OneSignal/ZeroSignal
- Natural sub-module: pipeline_hazard_detect. It is the purely combinational load-use comparator, producing load_use_o.

Test Plan:
- Load x5 in EX, ID uses rs2=x5 -> one cycle stall_o=00011, flush_o=00100; next cycle 0/0. Repeat with rd=x0 -> no stall.
- div_req_i at cycle 10, div_done_i at cycle 45 -> div_start_o at cycle 11 only; stall_o=00111 cycles 10..44; cycle 45 stall_o=0; no restart at cycle 46.
- mem_req_i held, no ack, MEM_TIMEOUT=4 -> stall_o=01111 for 4 cycles, then bus_err_o=1 single pulse, state RUN.
- branch_enable_i during MEM_WAIT, ack 3 cycles later -> flush_o=00110 in the first released cycle, exactly once.
- Branch and load-use in the same cycle -> flush_o=00110, stall_o=0.
- rst_i asserted mid-DIV_WAIT -> next cycle all outputs 0, state RUN; a later div_done_i is ignored.
